// File: rtl/switch_mcu_alu_shift_unit.sv
// switch_mcu_alu_shift_unit
//   Multi-cycle shift execution unit (SLL/SRL/SRA and immediate forms).
//   Reads rs1 (and rs2 for register forms) through the register-file read
//   ports, shifts STEP bits per cycle, and writes the result back through
//   the write port. All outputs are registered.
//
// Ports
//   in_clk, in_rst           clock (rising edge), async active-low reset
//   in_en                    unit enable; low aborts any operation
//   in_start                 start pulse, honoured only in IDLE with in_en=1
//   in_op                    00 SLL, 01 SRL, 11 SRA, 10 reserved
//   in_src_imm               1: shamt from in_imm_type_i, 0: shamt from rs2
//   in_imm_type_i            I-type immediate (low SHAMT_W bits used)
//   in_rs1/in_rs2/in_rd      register indices
//   in_rdata_1/in_rdata_2    read data (valid one cycle after read enable)
//   out_raddr_*/out_ren_*    read ports 1/2
//   out_waddr/out_wen/out_wdata  write port
//   out_busy                 high in every state except IDLE
//   out_done                 one-cycle completion pulse
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a start
// RD      | read enables asserted towards the register file
// CAP     | read data returned; capture operand and shift amount
// SHIFT   | shift by min(STEP, remaining) per cycle
// WB      | write result (unless rd=x0 or reserved op), pulse done

module switch_mcu_alu_shift_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_en,
    input  logic               in_start,
    input  logic [1:0]         in_op,
    input  logic               in_src_imm,
    input  logic [11:0]        in_imm_type_i,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [4:0]         in_rd,
    input  logic [XLEN-1:0]    in_rdata_1,
    input  logic [XLEN-1:0]    in_rdata_2,
    output logic [4:0]         out_raddr_1,
    output logic               out_ren_1,
    output logic [4:0]         out_raddr_2,
    output logic               out_ren_2,
    output logic [4:0]         out_waddr,
    output logic               out_wen,
    output logic [XLEN-1:0]    out_wdata,
    output logic               out_busy,
    output logic               out_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b10;

    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 src_imm_q, src_imm_d;
    logic [SHAMT_W-1:0]   imm_sh_q, imm_sh_d;
    logic [4:0]           rd_q, rd_d;
    logic [XLEN-1:0]      opnd_q, opnd_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;

    logic [4:0]           raddr_1_d, raddr_2_d, waddr_d;
    logic                 ren_1_d, ren_2_d, wen_d, busy_d, done_d;
    logic [XLEN-1:0]      wdata_d;

    logic [SHAMT_W-1:0]   cap_sh;
    logic [SHAMT_W:0]     rem_ext;
    logic [SHAMT_W:0]     amt;

    logic                 unused_bits;
    assign unused_bits = &{1'b0, in_imm_type_i[11:SHAMT_W], in_rdata_2[XLEN-1:SHAMT_W]};

    assign cap_sh  = src_imm_q ? imm_sh_q : in_rdata_2[SHAMT_W-1:0];
    assign rem_ext = {1'b0, rem_q};
    // Last iteration may need fewer than STEP bits.
    assign amt     = (rem_ext < STEP_W) ? rem_ext : STEP_W;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_imm_d = src_imm_q;
        imm_sh_d  = imm_sh_q;
        rd_d      = rd_q;
        opnd_d    = opnd_q;
        rem_d     = rem_q;
        raddr_1_d = '0;
        raddr_2_d = '0;
        ren_1_d   = 1'b0;
        ren_2_d   = 1'b0;
        waddr_d   = '0;
        wen_d     = 1'b0;
        wdata_d   = '0;
        done_d    = 1'b0;
        busy_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    state_d   = ST_RD;
                    op_d      = in_op;
                    src_imm_d = in_src_imm;
                    imm_sh_d  = in_imm_type_i[SHAMT_W-1:0];
                    rd_d      = in_rd;
                    ren_1_d   = 1'b1;
                    raddr_1_d = in_rs1;
                    if (!in_src_imm) begin
                        ren_2_d   = 1'b1;
                        raddr_2_d = in_rs2;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                opnd_d = in_rdata_1;
                rem_d  = cap_sh;
                if (op_q == OP_RSV || cap_sh == '0) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                case (op_q)
                    OP_SLL:  opnd_d = opnd_q << amt;
                    OP_SRL:  opnd_d = opnd_q >> amt;
                    default: opnd_d = $unsigned($signed(opnd_q) >>> amt);
                endcase
                rem_d = rem_q - amt[SHAMT_W-1:0];
                if (rem_d == '0) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable wins over everything, including a start in the same cycle.
        if (!in_en) begin
            state_d   = ST_IDLE;
            ren_1_d   = 1'b0;
            ren_2_d   = 1'b0;
            raddr_1_d = '0;
            raddr_2_d = '0;
        end

        // Outputs are registered, so the WB outputs are set on the edge
        // that enters WB, using the operand value being loaded that edge.
        if (state_d == ST_WB) begin
            done_d = 1'b1;
            if (rd_q != 5'd0 && op_q != OP_RSV) begin
                wen_d   = 1'b1;
                waddr_d = rd_q;
                wdata_d = opnd_d;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            src_imm_q   <= 1'b0;
            imm_sh_q    <= '0;
            rd_q        <= '0;
            opnd_q      <= '0;
            rem_q       <= '0;
            out_raddr_1 <= '0;
            out_ren_1   <= 1'b0;
            out_raddr_2 <= '0;
            out_ren_2   <= 1'b0;
            out_waddr   <= '0;
            out_wen     <= 1'b0;
            out_wdata   <= '0;
            out_busy    <= 1'b0;
            out_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_imm_q   <= src_imm_d;
            imm_sh_q    <= imm_sh_d;
            rd_q        <= rd_d;
            opnd_q      <= opnd_d;
            rem_q       <= rem_d;
            out_raddr_1 <= raddr_1_d;
            out_ren_1   <= ren_1_d;
            out_raddr_2 <= raddr_2_d;
            out_ren_2   <= ren_2_d;
            out_waddr   <= waddr_d;
            out_wen     <= wen_d;
            out_wdata   <= wdata_d;
            out_busy    <= busy_d;
            out_done    <= done_d;
        end
    end

endmodule

// File: tb/tb_switch_mcu_alu_shift_unit.sv
// Testbench for switch_mcu_alu_shift_unit. Two instances share the stimulus:
// index 0 uses STEP=1, index 1 uses STEP=8. A register-file model returns
// read data one cycle after a read enable (random junk otherwise).

module tb_switch_mcu_alu_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, start, src_imm;
    logic [1:0]  op;
    logic [11:0] imm;
    logic [4:0]  rs1, rs2, rd;

    logic [31:0] rdata1 [2];
    logic [31:0] rdata2 [2];
    logic [4:0]  raddr1 [2];
    logic [4:0]  raddr2 [2];
    logic [4:0]  waddr  [2];
    logic        ren1   [2];
    logic        ren2   [2];
    logic        wen    [2];
    logic        busy   [2];
    logic        done   [2];
    logic [31:0] wdata  [2];

    logic [31:0] regs [32];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    switch_mcu_alu_shift_unit #(.XLEN(32), .SHAMT_W(5), .STEP(1)) dut_s1 (
        .in_clk(clk), .in_rst(rst_n), .in_en(en), .in_start(start),
        .in_op(op), .in_src_imm(src_imm), .in_imm_type_i(imm),
        .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd),
        .in_rdata_1(rdata1[0]), .in_rdata_2(rdata2[0]),
        .out_raddr_1(raddr1[0]), .out_ren_1(ren1[0]),
        .out_raddr_2(raddr2[0]), .out_ren_2(ren2[0]),
        .out_waddr(waddr[0]), .out_wen(wen[0]), .out_wdata(wdata[0]),
        .out_busy(busy[0]), .out_done(done[0])
    );

    switch_mcu_alu_shift_unit #(.XLEN(32), .SHAMT_W(5), .STEP(8)) dut_s8 (
        .in_clk(clk), .in_rst(rst_n), .in_en(en), .in_start(start),
        .in_op(op), .in_src_imm(src_imm), .in_imm_type_i(imm),
        .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd),
        .in_rdata_1(rdata1[1]), .in_rdata_2(rdata2[1]),
        .out_raddr_1(raddr1[1]), .out_ren_1(ren1[1]),
        .out_raddr_2(raddr2[1]), .out_ren_2(ren2[1]),
        .out_waddr(waddr[1]), .out_wen(wen[1]), .out_wdata(wdata[1]),
        .out_busy(busy[1]), .out_done(done[1])
    );

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rdata1[k] <= ren1[k] ? regs[raddr1[k]] : $urandom();
            rdata2[k] <= ren2[k] ? regs[raddr2[k]] : $urandom();
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] a, int sh);
        logic signed [31:0] s;
        s = a;
        case (o)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b11:   return 32'(s >>> sh);
            default: return a;
        endcase
    endfunction

    function automatic int ref_lat(logic [1:0] o, int sh, int step);
        if (o == 2'b10) return 3;
        return 3 + (sh + step - 1) / step;
    endfunction

    task automatic chk_zero(string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/d%0d busy", tag, k), 32'(busy[k]), 0);
            chk($sformatf("%s/d%0d done", tag, k), 32'(done[k]), 0);
            chk($sformatf("%s/d%0d wen", tag, k), 32'(wen[k]), 0);
            chk($sformatf("%s/d%0d wdata", tag, k), wdata[k], 0);
            chk($sformatf("%s/d%0d ren", tag, k), {30'd0, ren1[k], ren2[k]}, 0);
            chk($sformatf("%s/d%0d addr", tag, k), {17'd0, raddr1[k], raddr2[k], waddr[k]}, 0);
        end
    endtask

    // Issue one operation and watch both instances cycle by cycle.
    // Cycle 1 is the first negedge after the accepting edge. xs>0 pulses a
    // second, different start in that cycle, which must be ignored.
    task automatic run_op(string tag, logic [1:0] o, logic si, logic [11:0] im,
                          logic [4:0] r1, logic [4:0] r2, logic [4:0] rdst,
                          logic [31:0] exp, int xs);
        int sh, maxc;
        int lat [2];
        int done_cnt [2], done_cyc [2], wen_cnt [2], wen_cyc [2];
        int busy_bad [2], idle_bad [2];
        logic [31:0] wd [2];
        logic [4:0]  wa [2];
        bit wr_exp;
        sh     = si ? int'(im[4:0]) : int'(regs[r2][4:0]);
        lat[0] = ref_lat(o, sh, 1);
        lat[1] = ref_lat(o, sh, 8);
        maxc   = lat[0] + 3;
        wr_exp = (rdst != 5'd0) && (o != 2'b10);
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0; done_cyc[k] = 0; wen_cnt[k] = 0; wen_cyc[k] = 0;
            busy_bad[k] = 0; idle_bad[k] = 0; wd[k] = '0; wa[k] = '0;
        end
        @(negedge clk);
        start = 1'b1; op = o; src_imm = si; imm = im; rs1 = r1; rs2 = r2; rd = rdst;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (c == 1) begin
                    chk($sformatf("%s/d%0d ren1", tag, k), 32'(ren1[k]), 1);
                    chk($sformatf("%s/d%0d raddr1", tag, k), 32'(raddr1[k]), 32'(r1));
                    chk($sformatf("%s/d%0d ren2", tag, k), 32'(ren2[k]), 32'(!si));
                    chk($sformatf("%s/d%0d raddr2", tag, k), 32'(raddr2[k]), si ? 0 : 32'(r2));
                end else if (ren1[k] || ren2[k] || raddr1[k] != 0 || raddr2[k] != 0) begin
                    idle_bad[k]++;
                end
                if (done[k]) begin done_cnt[k]++; done_cyc[k] = c; end
                if (wen[k]) begin
                    wen_cnt[k]++; wen_cyc[k] = c; wd[k] = wdata[k]; wa[k] = waddr[k];
                end else if (wdata[k] != 0 || waddr[k] != 0) begin
                    idle_bad[k]++;
                end
                if (busy[k] != (c <= lat[k])) busy_bad[k]++;
            end
            start = 1'b0;
            if (c == xs) begin
                start = 1'b1; op = 2'b00; src_imm = 1'b1; imm = 12'd1;
                rs1 = 5'($urandom()); rs2 = 5'($urandom()); rd = 5'd31;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/d%0d done_cnt", tag, k), 32'(done_cnt[k]), 1);
            chk($sformatf("%s/d%0d done_cyc", tag, k), 32'(done_cyc[k]), 32'(lat[k]));
            chk($sformatf("%s/d%0d wen_cnt", tag, k), 32'(wen_cnt[k]), 32'(wr_exp));
            if (wr_exp) begin
                chk($sformatf("%s/d%0d wen_cyc", tag, k), 32'(wen_cyc[k]), 32'(lat[k]));
                chk($sformatf("%s/d%0d wdata", tag, k), wd[k], exp);
                chk($sformatf("%s/d%0d waddr", tag, k), 32'(wa[k]), 32'(rdst));
            end
            chk($sformatf("%s/d%0d busy_seq", tag, k), 32'(busy_bad[k]), 0);
            chk($sformatf("%s/d%0d idle_ports", tag, k), 32'(idle_bad[k]), 0);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        si;
        logic [11:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, exp;
        int          xs;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int n_ev;
        logic [1:0]  ro;
        logic        rsi;
        logic [11:0] rim;
        logic [4:0]  r1, r2, rdst;
        int          sh;

        for (int i = 0; i < 32; i++) regs[i] = 32'($urandom());
        rst_n = 1'b0; en = 1'b1; start = 1'b0; op = '0; src_imm = 1'b0;
        imm = '0; rs1 = '0; rs2 = '0; rd = '0;

        tbl[0] = '{2'b11, 1'b1, 12'd4,     5'd5, 5'd6, 5'd7,  32'h8000_00F0, 32'h0,         32'hF800_000F, 0};
        tbl[1] = '{2'b01, 1'b0, 12'd0,     5'd1, 5'd2, 5'd9,  32'hF000_0000, 32'h0000_0024, 32'h0F00_0000, 0};
        tbl[2] = '{2'b00, 1'b1, 12'd0,     5'd3, 5'd4, 5'd4,  32'h0000_0001, 32'h0,         32'h0000_0001, 0};
        tbl[3] = '{2'b00, 1'b1, 12'd31,    5'd3, 5'd4, 5'd4,  32'h0000_0001, 32'h0,         32'h8000_0000, 0};
        tbl[4] = '{2'b00, 1'b1, 12'd3,     5'd3, 5'd4, 5'd0,  32'h0000_0001, 32'h0,         32'h0,         0};
        tbl[5] = '{2'b10, 1'b1, 12'd5,     5'd3, 5'd4, 5'd10, 32'h0000_0001, 32'h0,         32'h0,         0};
        tbl[6] = '{2'b11, 1'b0, 12'd0,     5'd8, 5'd9, 5'd11, 32'h8000_0001, 32'hFFFF_FFE1, 32'hC000_0000, 2};
        tbl[7] = '{2'b00, 1'b1, 12'd0,     5'd3, 5'd4, 5'd12, 32'h0000_0001, 32'h0,         32'h0000_0001, 3};
        tbl[8] = '{2'b01, 1'b1, 12'hFE5,   5'd8, 5'd9, 5'd13, 32'h8000_0001, 32'h0,         32'h0400_0000, 4};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("idle");

        foreach (tbl[i]) begin
            regs[tbl[i].rs1] = tbl[i].v1;
            regs[tbl[i].rs2] = tbl[i].v2;
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].si, tbl[i].imm,
                   tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].exp, tbl[i].xs);
        end

        // Abort by dropping the enable in the middle of SHIFT.
        regs[3] = 32'h0000_0001;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_imm = 1'b1; imm = 12'd20; rs1 = 5'd3; rs2 = 5'd4; rd = 5'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort/d0 busy_before", 32'(busy[0]), 1);
        chk("abort/d1 busy_before", 32'(busy[1]), 1);
        en = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        en = 1'b1;
        n_ev = 0;
        repeat (40) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (wen[k] || done[k] || busy[k]) n_ev++;
        end
        chk("abort/quiet", 32'(n_ev), 0);
        run_op("after_abort", 2'b00, 1'b1, 12'd20, 5'd3, 5'd4, 5'd5, 32'h0010_0000, 0);

        // Asynchronous reset in the middle of SHIFT.
        regs[3] = 32'h0000_0001;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_imm = 1'b1; imm = 12'd31; rs1 = 5'd3; rs2 = 5'd4; rd = 5'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("areset/d0 busy_before", 32'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("areset");
        @(negedge clk);
        rst_n = 1'b1;
        n_ev = 0;
        repeat (40) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (wen[k] || done[k] || busy[k]) n_ev++;
        end
        chk("areset/quiet", 32'(n_ev), 0);
        run_op("after_reset", 2'b00, 1'b1, 12'd31, 5'd3, 5'd4, 5'd6, 32'h8000_0000, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            ro   = 2'($urandom_range(0, 3));
            rsi  = 1'($urandom());
            rim  = 12'($urandom());
            r1   = 5'($urandom_range(1, 15));
            r2   = 5'($urandom_range(16, 31));
            rdst = (i % 7 == 0) ? 5'd0 : 5'($urandom());
            regs[r1] = 32'($urandom());
            regs[r2] = 32'($urandom());
            sh = rsi ? int'(rim[4:0]) : int'(regs[r2][4:0]);
            run_op($sformatf("rnd%0d", i), ro, rsi, rim, r1, r2, rdst,
                   ref_shift(ro, regs[r1], sh), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
